// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: program select, loader writes, PC sequencing.
// Define INSTR_FETCH_ICOUNT_EN to build the retired-fetch counter on icount.
module instr_fetch_ctrl #(
  parameter int BASE0     = 1,
  parameter int BASE1     = 15,
  parameter int BASE2     = 30,
  parameter int MEM_DEPTH = 81
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  prog_sel,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        redirect,
  input  logic [9:0]  redirect_addr,
  input  logic        ld_req,
  input  logic [9:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ack,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [9:0]  instr_pc,
  output logic        busy,
  output logic        error,
  output logic [15:0] icount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [9:0]  LP_B0    = 10'(BASE0);
  localparam logic [9:0]  LP_B1    = 10'(BASE1);
  localparam logic [9:0]  LP_B2    = 10'(BASE2);
  localparam logic [9:0]  LP_LAST  = 10'(MEM_DEPTH - 1);
  localparam logic [10:0] LP_DEPTH = 11'(MEM_DEPTH);

  state_t      r_state, w_state_n;
  state_t      r_ret, w_ret_n;
  logic [9:0]  r_pc, w_pc_n;
  logic [31:0] r_instr, w_instr_n;
  logic [9:0]  r_instr_pc, w_ipc_n;
  logic        r_instr_valid, w_vld_n;
  logic        r_error, w_err_n;
  logic [9:0]  r_ld_addr, w_lda_n;
  logic [31:0] r_ld_data, w_ldd_n;
  logic        w_ld_ok;
  logic        w_rd_ok;
  logic        w_in_load;

  assign w_ld_ok   = {1'b0, r_ld_addr} < LP_DEPTH;
  assign w_rd_ok   = {1'b0, redirect_addr} < LP_DEPTH;
  assign w_in_load = (r_state == S_LOAD);

  always_comb begin
    w_state_n = r_state;
    w_ret_n   = r_ret;
    w_pc_n    = r_pc;
    w_instr_n = r_instr;
    w_ipc_n   = r_instr_pc;
    w_vld_n   = 1'b0;
    w_err_n   = r_error;
    w_lda_n   = r_ld_addr;
    w_ldd_n   = r_ld_data;
    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (ld_req) begin
          w_lda_n   = ld_addr;
          w_ldd_n   = ld_data;
          w_ret_n   = r_state;
          w_state_n = S_LOAD;
        end else if (start) begin
          w_err_n   = 1'b0;
          w_state_n = S_RUN;
          unique case (prog_sel)
            2'd0: w_pc_n = LP_B0;
            2'd1: w_pc_n = LP_B1;
            2'd2: w_pc_n = LP_B2;
            default: begin
              w_err_n   = 1'b1;
              w_state_n = S_HALT;
            end
          endcase
        end
      end
      S_LOAD: begin
        w_state_n = r_ret;
        if (!w_ld_ok) w_err_n = 1'b1;
      end
      S_RUN: begin
        if (halt_req) begin
          w_state_n = S_HALT;
        end else if (redirect) begin
          if (w_rd_ok) begin
            w_pc_n = redirect_addr;
          end else begin
            w_err_n   = 1'b1;
            w_state_n = S_HALT;
          end
        end else if (!stall) begin
          w_instr_n = mem_rdata;
          w_ipc_n   = r_pc;
          w_vld_n   = 1'b1;
          // Last word is still delivered; only the increment faults
          if (r_pc == LP_LAST) begin
            w_err_n   = 1'b1;
            w_state_n = S_HALT;
          end else begin
            w_pc_n = r_pc + 10'd1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ret         <= S_IDLE;
      r_pc          <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_error       <= 1'b0;
      r_ld_addr     <= '0;
      r_ld_data     <= '0;
    end else begin
      r_state       <= w_state_n;
      r_ret         <= w_ret_n;
      r_pc          <= w_pc_n;
      r_instr       <= w_instr_n;
      r_instr_pc    <= w_ipc_n;
      r_instr_valid <= w_vld_n;
      r_error       <= w_err_n;
      r_ld_addr     <= w_lda_n;
      r_ld_data     <= w_ldd_n;
    end
  end

  // Reset gates the write strobes so an aborted load never lands
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      (r_state == S_RUN): mem_addr = r_pc;
      w_in_load: begin
        mem_addr  = r_ld_addr;
        mem_wdata = r_ld_data;
      end
      default: mem_addr = '0;
    endcase
  end

  assign mem_we      = w_in_load && w_ld_ok && !reset;
  assign ld_ack      = w_in_load && !reset;
  assign busy        = (r_state == S_RUN) || w_in_load;
  assign error       = r_error;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;

`ifdef INSTR_FETCH_ICOUNT_EN
  logic [15:0] r_icount;
  logic        w_clr;

  assign w_clr = ((r_state == S_IDLE) || (r_state == S_HALT))
               && !ld_req && start && (prog_sel != 2'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_icount <= '0;
    end else if (w_clr) begin
      r_icount <= '0;
    end else if (r_instr_valid && (r_icount != 16'hFFFF)) begin
      r_icount <= r_icount + 16'd1;
    end
  end

  assign icount = r_icount;
`else
  assign icount = '0;
`endif

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter BASE0, 1, start address of program 0 (fibonacci).
REQ-002 SHALL have parameter BASE1, 15, start address of program 1 (factorial).
REQ-003 SHALL have parameter BASE2, 30, start address of program 2 (synthetic).
REQ-004 SHALL have parameter MEM_DEPTH, 81, number of valid instruction words; legal addresses are 0..MEM_DEPTH-1.
REQ-005 SHALL have port clock  in  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports start in 1 (run request); prog_sel in 2 (program select); stall in 1 (hold PC); halt_req in 1 (stop execution).
REQ-008 SHALL have ports redirect in 1 (branch/jump taken) and redirect_addr in 10 (target address).
REQ-009 SHALL have ports ld_req in 1, ld_addr in 10, ld_data in 32 (loader write request) and ld_ack out 1 (write accepted).
REQ-010 SHALL have ports mem_addr out 10, mem_wdata out 32, mem_we out 1 (memory write enable) and mem_rdata in 32 (combinational read data).
REQ-011 SHALL have ports instr out 32, instr_valid out 1, instr_pc out 10, busy out 1, error out 1 and icount out 16.

Function
REQ-012 SHALL implement the states IDLE, LOAD, RUN and HALT.
REQ-013 IDLE: ld_req SHALL go to LOAD; otherwise start with prog_sel 0/1/2 SHALL load pc with BASE0/BASE1/BASE2 and go to RUN; start with prog_sel 3 SHALL set error and go to HALT.
REQ-014 IDLE with ld_req and start in the same cycle SHALL serve ld_req and drop start.
REQ-015 LOAD: SHALL drive mem_addr=ld_addr, mem_wdata=ld_data and mem_we=1 for exactly one cycle, pulse ld_ack the same cycle, then return to the state LOAD was entered from.
REQ-016 LOAD: an ld_addr >= MEM_DEPTH SHALL suppress mem_we, still pulse ld_ack, and set error.
REQ-017 RUN: SHALL drive mem_addr=pc and mem_we=0; ld_req SHALL be ignored (ld_ack=0) and the fetch path SHALL have priority.
REQ-018 RUN, no stall: the next cycle SHALL register instr=mem_rdata, instr_pc=pc and instr_valid=1, and SHALL set pc=pc+1; fetch latency is one cycle.
REQ-019 RUN, stall=1: pc, instr and instr_pc SHALL hold and instr_valid SHALL be 0.
REQ-020 RUN, redirect=1: pc SHALL load redirect_addr, and the word fetched in that cycle SHALL be squashed (instr_valid=0 next cycle); redirect SHALL take effect even while stall=1.
REQ-021 A redirect_addr >= MEM_DEPTH, or an increment with pc=MEM_DEPTH-1, SHALL set error, hold pc and go to HALT.
REQ-022 A halt_req SHALL go to HALT next cycle with instr_valid=0, and SHALL take priority over redirect and stall in the same cycle.
REQ-023 HALT: ld_req SHALL go to LOAD; start SHALL clear error and restart exactly as from IDLE.
REQ-024 busy SHALL be 1 in RUN and LOAD and 0 otherwise.
REQ-025 error SHALL be sticky until reset or an accepted start.

Reset
REQ-026 With reset=1 at a clock edge, the block SHALL enter IDLE with pc=0, instr=0, instr_pc=0, instr_valid=0, ld_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, error=0 and icount=0.
REQ-027 A reset during LOAD or RUN SHALL abort the operation, with no memory write and no ld_ack in the reset cycle.

Configuration
REQ-028 With macro INSTR_FETCH_ICOUNT_EN defined, icount SHALL increment once per cycle in which instr_valid=1, saturate at 16'hFFFF, and clear on reset and on an accepted start.
REQ-029 Without INSTR_FETCH_ICOUNT_EN, icount SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-030 Reset, then start with prog_sel=1 and no stall -> mem_addr=15,16,17 on consecutive cycles; instr_valid first asserts with instr_pc=15; busy=1.
REQ-031 In IDLE, ld_req with ld_addr=5 and ld_data=32'hDEADBEEF -> one cycle of mem_we=1 and ld_ack=1, then IDLE; the memory word at address 5 reads 32'hDEADBEEF.
REQ-032 In RUN at pc=22, redirect to 20 -> squashed slot (instr_valid=0), then instr_pc=20,21; with stall held 3 cycles -> pc frozen and instr_valid=0 for those cycles.
REQ-033 start with prog_sel=3, and separately redirect_addr=100 -> error=1 and HALT; a subsequent start with prog_sel=2 -> error=0 and fetch from address 30.
REQ-034 halt_req, redirect and ld_req all in one RUN cycle -> HALT, no redirect, ld_ack=0; ld_req next cycle -> accepted.
REQ-035 With INSTR_FETCH_ICOUNT_EN defined, 10 unstalled fetches -> icount=10; without the macro -> icount=0 throughout.
